// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core. The control FSM steps the datapath through a shared
// instruction/data memory port. Memory states hold until mem_ready completes the access.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          BNE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic        [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, alu_q, alu_d;
  logic signed [31:0] a_q, a_d, b_q, b_d;
  logic               retire_q, retire_d, illegal_q, illegal_d;

  logic [31:0] rf [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        [5:0]  opcode, funct;
  logic        [4:0]  rs, rt, rd;
  logic signed [31:0] imm_sx, rs_val, rt_val;
  logic        [32:0] rtype_res;
  logic               br_taken;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rs_val = (rs == 5'd0) ? 32'sd0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'sd0 : rf[rt];

  // R-type ALU: {legal, result}; an unknown funct clears the legal bit.
  function automatic logic [32:0] alu_rtype(input logic [5:0] fn,
                                            input logic signed [31:0] x,
                                            input logic signed [31:0] y);
    case (fn)
      6'h20:   return {1'b1, 32'(x + y)};
      6'h22:   return {1'b1, 32'(x - y)};
      6'h24:   return {1'b1, 32'(x & y)};
      6'h25:   return {1'b1, 32'(x | y)};
      6'h2A:   return {1'b1, (x < y) ? 32'd1 : 32'd0};
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  assign rtype_res = alu_rtype(funct, a_q, b_q);
  assign br_taken  = (opcode == 6'h04) ? (a_q == b_q) : (a_q != b_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    retire_d  = 1'b0;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_q;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        alu_d = pc_q + {imm_sx[29:0], 2'b00};
        case (opcode)
          6'h00:        state_d = S_EXEC;
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h04:        state_d = S_BRANCH;
          6'h05:        state_d = BNE_EN ? S_BRANCH : S_ERR;
          6'h08:        state_d = S_ADDIEX;
          6'h02:        state_d = S_JUMP;
          default:      state_d = S_ERR;
        endcase
      end
      S_EXEC: begin
        alu_d   = rtype_res[31:0];
        state_d = rtype_res[32] ? S_ALUWB : S_ERR;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMADR: begin
        alu_d   = a_q + imm_sx;
        state_d = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: if (mem_ready) begin
        mdr_d   = mem_rdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: if (mem_ready) begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        if (br_taken) pc_d = alu_q;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = a_q + imm_sx;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_ERR: begin
        illegal_d = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
    end
  end

  // Register file is not reset; $0 is never written and always reads as zero.
  always_ff @(posedge clk) begin
    if (rf_we && !reset && (rf_waddr != 5'd0)) rf[rf_waddr] <= rf_wdata;
  end

  assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign mem_we    = (state_q == S_MEMWR);
  assign mem_addr  = (state_q == S_FETCH) ? pc_q : alu_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: an instruction-level model checks every retirement of
// core A (bne disabled); core B exercises jumps in a high PC segment and enabled bne.
`timescale 1ns/1ps
module tb_multicycle_datapath;
  localparam logic [31:0] RPC_A = 32'h0000_0100;
  localparam logic [31:0] RPC_B = 32'h1000_0000;
  localparam bit          BNE_A = 1'b0;
  localparam int          NPROG = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        req_a, we_a, rdy_a, ret_a, ill_a;
  logic [31:0] addr_a, wd_a, rd_a, pc_a;
  logic        req_b, we_b, rdy_b, ret_b, ill_b;
  logic [31:0] addr_b, wd_b, rd_b, pc_b;

  multicycle_datapath #(.RESET_PC(RPC_A), .BNE_EN(BNE_A)) dut_a (
    .clk(clk), .reset(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wd_a), .mem_rdata(rd_a), .mem_ready(rdy_a), .pc(pc_a),
    .retire(ret_a), .illegal(ill_a));

  multicycle_datapath #(.RESET_PC(RPC_B), .BNE_EN(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wd_b), .mem_rdata(rd_b), .mem_ready(rdy_b), .pc(pc_b),
    .retire(ret_b), .illegal(ill_b));

  int n_tests = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [31:0] prog [NPROG] = '{
    32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0008,  // addi,addi,add,sw
    32'h8C04_0008, 32'hAC04_000C, 32'h2006_FFFF, 32'h2007_0001,  // lw,sw,addi -1,addi 1
    32'h00C7_282A, 32'h0007_4022, 32'h0022_0020, 32'hAC05_0010,  // slt,sub,add $0,sw
    32'hAC08_0014, 32'hAC00_0018, 32'h0022_4824, 32'h0022_5025,  // sw,sw,and,or
    32'hAC09_001C, 32'hAC0A_0020, 32'h1022_0001, 32'h1021_0003,  // sw,sw,beq nt,beq fwd
    32'h1422_0000, 32'h0800_0058, 32'h0800_0054, 32'h1021_FFFE,  // bne,j 0x160,j 0x150,beq -2
    32'h0000_0001, 32'hAC03_0028                                  // bad funct, sw (held)
  };

  logic [31:0] mem_a [logic [31:0]];
  logic [31:0] mm    [logic [31:0]];
  logic [63:0] wq[$], wlog[$];
  logic [31:0] ret_edges[$], b_pcs[$];
  logic [31:0] m_r [32];
  logic [31:0] m_pc;
  logic        m_ill, chk_en, ill_seen;
  int          stall_rd, rd8_cycles, edge_n, b_wr_cnt;

  function automatic logic [31:0] q32_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [63:0] q64_at(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic logic [31:0] mem_b(input logic [31:0] a);
    case (a)
      32'h1000_0000: return 32'h0800_0040;  // j -> 0x1000_0100
      32'h1000_0100: return 32'h2001_0001;  // addi $1,$0,1
      32'h1000_0104: return 32'h1420_0003;  // bne $1,$0,+3 (taken)
      32'h1000_0114: return 32'h1421_0005;  // bne $1,$1,+5 (not taken)
      32'h1000_0118: return 32'h0800_0046;  // j self
      default:       return 32'h0;
    endcase
  endfunction

  // Memory for core A: optional read stall on address 0x8, permanent stall on stores to 0x28.
  always @(negedge clk) begin
    if (req_a && !we_a && addr_a == 32'h8 && stall_rd > 0) begin
      rdy_a = 1'b0;
      stall_rd--;
    end else if (req_a && we_a && addr_a == 32'h28) rdy_a = 1'b0;
    else rdy_a = 1'b1;
    rd_a = mem_a.exists(addr_a) ? mem_a[addr_a] : 32'h0;
    if (req_a && we_a && rdy_a) begin
      mem_a[addr_a] = wd_a;
      wq.push_back({addr_a, wd_a});
      wlog.push_back({addr_a, wd_a});
    end
    if (req_a && !we_a && addr_a == 32'h8) rd8_cycles++;
  end

  always @(negedge clk) begin
    rdy_b = 1'b1;
    rd_b  = mem_b(addr_b);
    if (req_b && we_b) b_wr_cnt++;
    if (!rst_b && ret_b && b_pcs.size() < 5) b_pcs.push_back(pc_b);
  end

  always @(posedge clk) if (!rst_a) edge_n++;

  function automatic void mw(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_r[r] = v;
  endfunction

  // Architectural model: run one instruction, skipping (and flagging) illegal ones.
  task automatic model_step();
    logic [31:0] ins, simm, ea, x, y;
    logic [63:0] w;
    bit done;
    done = 1'b0;
    for (int g = 0; g < 4 && !done; g++) begin
      ins  = mm.exists(m_pc) ? mm[m_pc] : 32'h0;
      m_pc = m_pc + 32'd4;
      simm = {{16{ins[15]}}, ins[15:0]};
      x    = m_r[ins[25:21]];
      y    = m_r[ins[20:16]];
      ea   = x + simm;
      done = 1'b1;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20:   mw(ins[15:11], x + y);
          6'h22:   mw(ins[15:11], x - y);
          6'h24:   mw(ins[15:11], x & y);
          6'h25:   mw(ins[15:11], x | y);
          6'h2A:   mw(ins[15:11], ($signed(x) < $signed(y)) ? 32'd1 : 32'd0);
          default: begin m_ill = 1'b1; done = 1'b0; end
        endcase
        6'h08: mw(ins[20:16], ea);
        6'h23: mw(ins[20:16], mm.exists(ea) ? mm[ea] : 32'h0);
        6'h2B: begin
          mm[ea] = y;
          check("store_count", 32'(wq.size()), 32'd1);
          if (wq.size() > 0) begin
            w = wq.pop_front();
            check("store_addr", w[63:32], ea);
            check("store_data", w[31:0], y);
          end
        end
        6'h04: if (x == y) m_pc = m_pc + (simm << 2);
        6'h05: if (BNE_A) begin
          if (x != y) m_pc = m_pc + (simm << 2);
        end else begin
          m_ill = 1'b1;
          done  = 1'b0;
        end
        6'h02: m_pc = {m_pc[31:28], ins[25:0], 2'b00};
        default: begin m_ill = 1'b1; done = 1'b0; end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && ret_a) begin
      ret_edges.push_back(32'(edge_n));
      model_step();
      check("retire_pc", pc_a, m_pc);
      check("retire_illegal", {31'b0, ill_a}, {31'b0, m_ill});
    end
    if (chk_en && ill_a && !ill_seen) begin
      ill_seen = 1'b1;
      check("post_illegal_fetch_addr", addr_a, 32'h154);
      check("post_illegal_fetch_req", {31'b0, req_a}, 32'd1);
    end
  end

  initial begin
    logic [31:0] wexp_a [7] = '{32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    logic [31:0] wexp_d [7] = '{32'd12, 32'd12, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd7};
    logic [31:0] bexp   [5] = '{32'h1000_0100, 32'h1000_0104, 32'h1000_0114,
                               32'h1000_0118, 32'h1000_0118};
    logic [63:0] w;
    bit hung;
    rst_a = 1'b1; rst_b = 1'b1; chk_en = 1'b0; ill_seen = 1'b0;
    rdy_a = 1'b0; rd_a = '0; rdy_b = 1'b0; rd_b = '0;
    stall_rd = 3; rd8_cycles = 0; edge_n = 0; b_wr_cnt = 0;
    for (int i = 0; i < NPROG; i++) begin
      mem_a[RPC_A + 32'(4 * i)] = prog[i];
      mm[RPC_A + 32'(4 * i)]    = prog[i];
    end
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_pc = RPC_A; m_ill = 1'b0;
    #2;
    check("rst_req", {31'b0, req_a}, 32'd1);
    check("rst_we", {31'b0, we_a}, 32'd0);
    check("rst_addr", addr_a, 32'h100);
    check("rst_pc", pc_a, 32'h100);
    check("rst_retire", {31'b0, ret_a}, 32'd0);
    check("rst_illegal", {31'b0, ill_a}, 32'd0);
    check("rst_b_addr", addr_b, 32'h1000_0000);
    check("rst_b_req", {31'b0, req_b}, 32'd1);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("pc_after_first_fetch", pc_a, 32'h104);

    hung = 1'b0;
    for (int i = 0; i < 400 && !hung; i++) begin
      @(negedge clk);
      hung = req_a && we_a && (addr_a == 32'h28);
    end
    check("held_store_reached", {31'b0, hung}, 32'd1);
    check("held_store_wdata", wd_a, 32'd12);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    check("abort_req", {31'b0, req_a}, 32'd1);
    check("abort_we", {31'b0, we_a}, 32'd0);
    check("abort_addr", addr_a, 32'h100);
    check("abort_pc", pc_a, 32'h100);
    repeat (3) @(negedge clk);
    check("abort_pc_held", pc_a, 32'h100);
    check("abort_retire", {31'b0, ret_a}, 32'd0);

    check("retire_count", 32'(ret_edges.size()), 32'd23);
    check("retire_edge_addi1", q32_at(ret_edges, 0), 32'd4);
    check("retire_edge_addi2", q32_at(ret_edges, 1), 32'd8);
    check("retire_edge_add", q32_at(ret_edges, 2), 32'd12);
    check("retire_edge_sw", q32_at(ret_edges, 3), 32'd16);
    check("retire_edge_lw_wait3", q32_at(ret_edges, 4), 32'd24);
    check("retire_edge_beq_nt", q32_at(ret_edges, 18), 32'd79);
    check("retire_edge_j", q32_at(ret_edges, 21), 32'd88);
    check("retire_edge_after_illegal", q32_at(ret_edges, 22), 32'd94);
    check("lw_addr_stable_cycles", 32'(rd8_cycles), 32'd4);
    check("write_count", 32'(wlog.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      w = q64_at(wlog, i);
      check($sformatf("write%0d_addr", i), w[63:32], wexp_a[i]);
      check($sformatf("write%0d_data", i), w[31:0], wexp_d[i]);
    end
    check("unmatched_writes", 32'(wq.size()), 32'd0);
    check("illegal_sticky", {31'b0, ill_a}, 32'd0);

    for (int i = 0; i < 5; i++) check($sformatf("b_retire%0d_pc", i), q32_at(b_pcs, i), bexp[i]);
    check("b_illegal", {31'b0, ill_b}, 32'd0);
    check("b_writes", 32'(b_wr_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
Multicycle MIPS-subset core: datapath plus internal control FSM, sharing one memory port for instructions and data. Successor to the single-cycle datapath. Adds a variable-latency memory handshake, configurable reset vector, optional BNE, and illegal-opcode detection. Sits between the top level and a unified instruction/data memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BNE_EN, 1, 1 = opcode 0x05 (bne) is legal; 0 = treated as illegal

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read; valid only while mem_req=1
mem_addr  output  32  byte address (word aligned)
mem_wdata  output  32  store data
mem_rdata  input  32  read data, valid in the cycle mem_ready=1
mem_ready  input  1  completes the current request
pc  output  32  current PC register
retire  output  1  one-cycle pulse when an instruction completes
illegal  output  1  sticky flag: undecoded opcode/funct seen

Behaviour:
- Registers: PC, IR, MDR, A, B, ALUOut, regfile 32x32. $0 reads 0; writes to $0 are ignored.
- Reset (async): PC=RESET_PC; IR, MDR, A, B, ALUOut = 0; state=FETCH; illegal=0; retire=0. Regfile is not reset.
- mem_req is decoded from state: 1 in FETCH/MEMRD/MEMWR, 0 elsewhere. Right after reset, mem_req=1 with mem_addr=RESET_PC and mem_we=0.
- Handshake: a memory state holds while mem_ready=0. mem_addr, mem_we and mem_wdata stay stable. mem_ready while mem_req=0 is ignored.
- FETCH: addr=PC. On ready: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE: A<=rf[rs], B<=rf[rt]. ALUOut<=PC+(signext(imm)<<2), the branch target relative to the updated PC. Dispatch on opcode:
  - 0x00 -> EXEC
  - 0x23/0x2B -> MEMADR
  - 0x04, or 0x05 when BNE_EN=1 -> BRANCH
  - 0x08 -> ADDIEX
  - 0x02 -> JUMP
  - otherwise -> ERR
- EXEC: ALUOut<=A op B. Funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1 or 0). Any other funct -> ERR. Then ALUWB.
- ALUWB: rf[rd]<=ALUOut; retire=1; go to FETCH.
- MEMADR: ALUOut<=A+signext(imm). lw -> MEMRD; sw -> MEMWR.
- MEMRD: addr=ALUOut, we=0. On ready: MDR<=mem_rdata, go to MEMWB.
- MEMWB: rf[rt]<=MDR; retire; go to FETCH.
- MEMWR: addr=ALUOut, we=1, wdata=B. On ready: retire, go to FETCH.
- BRANCH: PC<=ALUOut if (A==B) for beq or (A!=B) for bne; retire; go to FETCH.
- ADDIEX: ALUOut<=A+signext(imm); go to ADDIWB. ADDIWB: rf[rt]<=ALUOut; retire; go to FETCH.
- JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; retire; go to FETCH.
- ERR: illegal<=1; no architectural writes; go to FETCH (instruction skipped, no retire).
- Arithmetic is 32-bit modulo with no overflow trap. PC wraps 0xFFFF_FFFC -> 0.
- Latency with zero-wait memory (cycles from FETCH entry to retire):
  - R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction aborts it. No partial register write occurs after reset assertion. A pending mem_req drops asynchronously to the FETCH request at RESET_PC.
- retire and a regfile write occur in the same cycle. rf reads in DECODE see the write from the previous cycle.

Test Plan:
- Reset with RESET_PC=0x100, mem_ready=1 -> first request addr=0x100, we=0; pc=0x104 after FETCH.
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,8($0) -> write addr=0x8, wdata=12; retire pulses at cycles 4, 8, 12, 16.
- lw $4,8($0) with mem_ready held low 3 cycles during MEMRD -> addr stable for 4 cycles, $4=12, retire at cycle 8.
- beq $1,$1,-2 at PC=0x10 -> pc=0x0C; bne with BNE_EN=0 -> illegal=1, no retire, next fetch at 0x14.
- slt $5,$6,$7 with $6=0xFFFFFFFF, $7=1 -> $5=1; sub 0-1 -> 0xFFFFFFFF; add $0,$1,$2 -> $0 still reads 0.
- j 0x40 at PC=0x1000_0000 -> pc=0x1000_0100. Assert reset during MEMWR wait -> no write completes, pc=RESET_PC.
